// File: rtl/serial_adder_ctrl_if.sv
// Start/done handshake plus operand and result bus for serial_adder_ctrl.
// Carries the ovf flag only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout, ovf
   );
`else
   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout
   );
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder stepped LSB first over WIDTH bits.
// Optional signed-overflow flag under macro SERIAL_ADDER_OVF_EN.
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input logic           clk,
   input logic           rst,
   serial_adder_ctrl_if.slave bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             accept;
   logic             step;
   logic             last;
   logic             bit_s;
   logic             carry_nxt;
   logic [WIDTH-1:0] sum_nxt;

   assign bit_s     = a_sh[0] ^ b_sh[0] ^ carry;
   assign carry_nxt = (a_sh[0] & b_sh[0])
                    | (a_sh[0] & carry)
                    | (b_sh[0] & carry);

   // Partial sum: the upper WIDTH-1 bits shift down as each new bit lands
   // at the MSB; the final step's view is the complete result.
   if (WIDTH > 1) begin : g_acc
      logic [WIDTH-2:0] acc;

      // Accumulate sum bits from the top down.
      always_ff @(posedge clk) begin
         if (rst || accept) begin
            acc <= '0;
         end else if (step) begin
            acc <= sum_nxt[WIDTH-1:1];
         end
      end

      assign sum_nxt = {bit_s, acc};
   end else begin : g_one
      assign sum_nxt = bit_s;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and datapath controls; DONE accepts like IDLE.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      step      = 1'b0;
      last      = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               accept    = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            step = 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
               last      = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (bus.start) begin
               accept    = 1'b1;
               state_nxt = SHIFT;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Operand shifters, carry and bit counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh  <= '0;
         b_sh  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
      end else if (accept) begin
         a_sh  <= bus.a;
         b_sh  <= bus.b;
         carry <= bus.cin;
         cnt   <= '0;
      end else if (step) begin
         a_sh  <= a_sh >> 1;
         b_sh  <= b_sh >> 1;
         carry <= carry_nxt;
         cnt   <= cnt + 1'b1;
      end
   end

   // Result registers change only on the completion edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else if (last) begin
         sum_q  <= sum_nxt;
         cout_q <= carry_nxt;
      end
   end

`ifdef SERIAL_ADDER_OVF_EN
   logic ovf_q;

   // Signed overflow: carry into the MSB step differs from carry out.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (last) begin
         ovf_q <= carry ^ carry_nxt;
      end
   end

   assign bus.ovf = ovf_q;
`else
`endif

   assign bus.busy = (state == SHIFT);
   assign bus.done = (state == DONE);
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized bench for serial_adder_ctrl with an arithmetic reference model.
// Define SERIAL_ADDER_OVF_EN to also check the ovf flag.
module tb_serial_adder_ctrl;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   serial_adder_ctrl_if #(.WIDTH(W)) bus ();

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   // Model: an op occupies W edges after acceptance, then result shows.
   int         rem;
   logic [W:0] pend;
   logic [W:0] res;
   logic       pend_ovf;
   logic       m_ovf;
   logic       m_done;
   logic       armed = 1'b0;

   always @(posedge clk) begin
      m_done = 1'b0;
      if (rst) begin
         rem   = 0;
         res   = '0;
         m_ovf = 1'b0;
         armed = 1'b1;
      end else if (rem == 0 && bus.start) begin
         rem  = W;
         pend = {1'b0, bus.a} + {1'b0, bus.b} + {{W{1'b0}}, bus.cin};
         pend_ovf = (bus.a[W-1] == bus.b[W-1])
                 && (pend[W-1] != bus.a[W-1]);
      end else if (rem > 0) begin
         rem--;
         if (rem == 0) begin
            res    = pend;
            m_ovf  = pend_ovf;
            m_done = 1'b1;
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (armed) begin
         chk("busy", bus.busy, (rem > 0));
         chk("done", bus.done, m_done);
         chk("sum", bus.sum, res[W-1:0]);
         chk("cout", bus.cout, res[W]);
`ifdef SERIAL_ADDER_OVF_EN
         chk("ovf", bus.ovf, m_ovf);
`endif
      end
   end

   task automatic run_add(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input logic [W-1:0] es,
                          input logic ec, input string nm);
      int lat;
      @(negedge clk);
      bus.a     = x;
      bus.b     = y;
      bus.cin   = c;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      bus.cin   = 1'($urandom);
      lat = 1;
      while (!bus.done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk({nm, "_lat"}, lat, W + 1);
      chk({nm, "_sum"}, bus.sum, es);
      chk({nm, "_cout"}, bus.cout, ec);
      chk({nm, "_model"}, res, {ec, es});
   endtask

   task automatic no_done(input int n, input string nm);
      int seen = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (bus.done) seen++;
      end
      chk(nm, seen, 0);
   endtask

   initial begin
      int n;
      int cnt;
      int t_prev;
      int lat;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.cin   = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_sum", bus.sum, 0);
      chk("rst_cout", bus.cout, 0);

      run_add(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, "add_3_4");
      run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add_ff_1");
      run_add(8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1, "add_5a_a5");

      // Start held high: back-to-back accepts from DONE.
      @(negedge clk);
      bus.a     = 8'h10;
      bus.b     = 8'h20;
      bus.cin   = 1'b0;
      bus.start = 1'b1;
      n      = 0;
      cnt    = 0;
      t_prev = -1;
      while (n < 3 && cnt < 100) begin
         @(negedge clk);
         cnt++;
         if (bus.done) begin
            n++;
            chk("b2b_sum", bus.sum, 8'h30);
            if (t_prev >= 0) chk("b2b_gap", cnt - t_prev, W + 1);
            t_prev = cnt;
            if (n == 3) bus.start = 1'b0;
         end
      end
      bus.start = 1'b0;
      chk("b2b_count", n, 3);

      // Start during SHIFT is ignored.
      @(negedge clk);
      bus.a     = 8'h01;
      bus.b     = 8'h01;
      bus.cin   = 1'b0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      bus.a     = 8'hAA;
      bus.b     = 8'hAA;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      lat = 4;
      while (!bus.done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("ign_lat", lat, W + 1);
      chk("ign_sum", bus.sum, 8'h02);
      chk("ign_cout", bus.cout, 0);
      no_done(15, "ign_extra_done");

      // Reset on the 4th SHIFT cycle discards the op.
      @(negedge clk);
      bus.a     = 8'h03;
      bus.b     = 8'h04;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mrst_busy", bus.busy, 0);
      chk("mrst_done", bus.done, 0);
      chk("mrst_sum", bus.sum, 0);
      chk("mrst_cout", bus.cout, 0);
      no_done(15, "mrst_no_done");
      run_add(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, "post_rst");

`ifdef SERIAL_ADDER_OVF_EN
      run_add(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, "ovf_7f");
      chk("ovf_7f_flag", bus.ovf, 1);
      run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ovf_ff");
      chk("ovf_ff_flag", bus.ovf, 0);
`endif

      // Random traffic, checked cycle by cycle by the compare process.
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         rst       = ($urandom_range(0, 149) == 0);
         bus.start = ($urandom_range(0, 2) == 0);
         bus.a     = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
         bus.b     = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
         bus.cin   = 1'($urandom);
      end
      @(negedge clk);
      rst       = 1'b0;
      bus.start = 1'b0;
      repeat (12) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
